// File: rtl/edge_pulse_gen.sv
// Multi-channel edge detector: each channel synchronizes an async gate
// and fires a fixed-width pulse on selected edges, with an edge counter.
module edge_pulse_gen #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PW_BITS     = 8,
  parameter int CNT_BITS    = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NCH-1:0]          gate_i,
  input  logic [2*NCH-1:0]        edge_sel_i,
  input  logic [PW_BITS-1:0]      pw_i,
  input  logic                    retrig_i,
  input  logic                    cnt_clr_i,
  output logic [NCH-1:0]          pulse_o,
  output logic [NCH*CNT_BITS-1:0] edge_cnt_o,
  output logic [NCH-1:0]          ovf_o
);

  localparam int ARM_N = SYNC_STAGES + 1;

  logic [2:0]         arm_cnt;
  logic               armed;
  logic [PW_BITS-1:0] pw_eff;

  assign armed  = (arm_cnt == 3'(ARM_N));
  assign pw_eff = (pw_i == '0) ? PW_BITS'(1) : pw_i;

  // Edges are masked until the synchronizer and prev stage hold post-reset data
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 3'd1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [PW_BITS-1:0]     rem_q;
    logic [CNT_BITS-1:0]    cnt_q;
    logic                   ovf_q;
    logic                   last;
    logic                   rise;
    logic                   fall;
    logic                   qual;
    logic                   load;

    assign last = sync_q[SYNC_STAGES-1];
    assign rise = last & ~prev_q;
    assign fall = ~last & prev_q;
    assign qual = armed &
                  ((rise & edge_sel_i[2*c]) |
                   (fall & edge_sel_i[2*c+1]));
    assign load = qual & ((rem_q == '0) | retrig_i);

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        sync_q <= '0;
        prev_q <= 1'b0;
        rem_q  <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], gate_i[c]};
        prev_q <= last;
        if (load) begin
          rem_q <= pw_eff;
        end else if (rem_q != '0) begin
          rem_q <= rem_q - PW_BITS'(1);
        end
      end
    end

    // Counter saturates at all-ones; further edges set the sticky flag
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (cnt_clr_i) begin
        cnt_q <= qual ? CNT_BITS'(1) : '0;
        ovf_q <= 1'b0;
      end else if (qual) begin
        if (cnt_q == '1) begin
          ovf_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_BITS'(1);
        end
      end
    end

    assign pulse_o[c]                        = (rem_q != '0);
    assign edge_cnt_o[c*CNT_BITS +: CNT_BITS] = cnt_q;
    assign ovf_o[c]                          = ovf_q;
  end

endmodule

// File: doc/edge_pulse_gen.md
EDGE_PULSE_GEN -- requirements
Module: edge_pulse_gen

Interface
REQ-001 Parameter NCH, default 4: number of independent channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth per channel (2..4).
REQ-003 Parameter PW_BITS, default 8: pulse-width field width.
REQ-004 Parameter CNT_BITS, default 16: per-channel edge-counter width.
REQ-005 clk_i  in  1: single clock; all logic SHALL run on its rising edge.
REQ-006 reset_i  in  1: reset, synchronous, active-high.
REQ-007 gate_i  in  NCH: asynchronous level inputs, one per channel.
REQ-008 edge_sel_i  in  2*NCH: per-channel select, bits [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 pw_i  in  PW_BITS: output pulse width in clk_i cycles, shared by all channels.
REQ-010 retrig_i  in  1: 1 = retriggerable, 0 = non-retriggerable.
REQ-011 cnt_clr_i  in  1: synchronous clear of all edge counters and overflow flags.
REQ-012 pulse_o  out  NCH: per-channel output pulse.
REQ-013 edge_cnt_o  out  NCH*CNT_BITS: per-channel edge count, channel c at [c*CNT_BITS +: CNT_BITS].
REQ-014 ovf_o  out  NCH: per-channel sticky counter-overflow flag.

Function
REQ-015 Each gate_i bit SHALL pass through a SYNC_STAGES-deep flip-flop chain followed by one "previous" register; edge = last-stage value differing from "previous".
REQ-016 Qualified edge: rising (0->1) when sel[0]=1, falling (1->0) when sel[1]=1; sel=00 ignores all edges.
REQ-017 Latency: gate_i transition first sampled at clock edge k SHALL drive pulse_o high after clock edge k+SYNC_STAGES.
REQ-018 Each channel SHALL hold a PW_BITS down-counter rem; pulse_o[c] = (rem != 0), decoded from registers only, with no combinational path from any input.
REQ-019 On qualified edge with rem==0: rem loads max(pw_i,1); pw_i==0 SHALL be treated as 1.
REQ-020 On qualified edge with rem!=0: retrig_i=1 reloads max(pw_i,1); retrig_i=0 ignores the edge for pulse purposes.
REQ-021 Without a load, rem decrements by 1 when nonzero; pulse therefore lasts exactly max(pw_i,1) cycles from the last accepted load.
REQ-022 pw_i, retrig_i, edge_sel_i SHALL be sampled only in the load cycle; changes during an active pulse do not alter it.
REQ-023 Every qualified edge, accepted or ignored, SHALL increment edge_cnt by 1; at all-ones the counter holds and ovf sets and remains set.
REQ-024 cnt_clr_i=1 clears edge_cnt and ovf for all channels; a qualified edge in the same cycle SHALL give edge_cnt=1, ovf=0.
REQ-025 cnt_clr_i SHALL NOT affect rem or pulse_o.
REQ-026 Channels SHALL be fully independent; simultaneous edges on all channels are each handled per REQ-019..024.
REQ-027 Gate activity shorter than one clk_i period is not guaranteed to be detected.

Reset
REQ-028 While reset_i=1: synchronizer chains, "previous" registers, rem, edge_cnt, ovf cleared to 0; pulse_o=0.
REQ-029 Arm window: edge detection SHALL be masked for SYNC_STAGES+1 cycles after reset_i deasserts while the chain fills; gate_i held high through reset SHALL produce no pulse and no count.
REQ-030 reset_i asserted mid-pulse SHALL force pulse_o low on the next clock edge.

Verification
REQ-031 SYNC_STAGES=2, pw_i=5, sel=01, gate_i[0] rises at edge 10 -> pulse_o[0] high after edges 12..16 (5 cycles), edge_cnt[0]=1.
REQ-032 pw_i=0, sel=11, one rise and, 10 cycles later, one fall -> two 1-cycle pulses, edge_cnt=2.
REQ-033 pw_i=8, sel=01, retrig_i=0, second rise 3 cycles after first -> single 8-cycle pulse, edge_cnt=2; retrig_i=1 -> pulse lasts 3+8=11 cycles.
REQ-034 CNT_BITS=4, 16 rising edges -> edge_cnt=15, ovf=1; then cnt_clr_i together with an edge -> edge_cnt=1, ovf=0.
REQ-035 gate_i=all-ones during reset, release reset -> no pulse_o, edge_cnt=0; reset_i during active pulse -> pulse_o=0 next cycle.
REQ-036 NCH=4, simultaneous rises on all channels with sel=01,10,11,00 -> pulses on channels 0 and 2 only.
